// File: rtl/morse_char_decoder.sv
// Morse character decoder: turns completed capture-stage characters
// into ASCII, inserts spaces at word gaps and buffers the text in a FIFO.
module morse_char_decoder #(
    parameter int MAX_LEN = 6,
    parameter int LEN_W   = 3,
    parameter int DEPTH   = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LEN_W-1:0]         len,
    input  logic [MAX_LEN-1:0]       dits_dahs,
    input  logic                     error,
    input  logic                     char_end,
    input  logic                     word_end,
    output logic                     cap_clr,
    output logic [7:0]               out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
    localparam logic [7:0] QMARK = 8'h3F;
    localparam logic [7:0] SPC   = 8'h20;

    typedef enum logic [1:0] {IDLE, EMIT, SPACE} state_t;

    state_t               state, state_nxt;
    logic                 space_pending, sp_nxt;
    logic                 latch_en;
    logic [LEN_W-1:0]     lat_len;
    logic [MAX_LEN-1:0]   lat_pat;
    logic                 lat_err;
    logic                 push;
    logic [7:0]           push_data;
    logic                 do_pop, do_write;
    logic [7:0]           mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;
    logic [CNT_W-1:0]     count;

    // Pattern is written first-symbol-first, dit = 1, dah = 0.
    function automatic logic [7:0] decode(
        input logic [LEN_W-1:0]   l,
        input logic [MAX_LEN-1:0] p,
        input logic               e
    );
        logic [7:0] c;
        c = QMARK;
        case (int'(l))
            1: c = p[0] ? 8'h45 : 8'h54;
            2: case (p[1:0])
                2'b11:   c = 8'h49;
                2'b10:   c = 8'h41;
                2'b01:   c = 8'h4E;
                default: c = 8'h4D;
            endcase
            3: case (p[2:0])
                3'b111:  c = 8'h53;
                3'b110:  c = 8'h55;
                3'b101:  c = 8'h52;
                3'b100:  c = 8'h57;
                3'b011:  c = 8'h44;
                3'b010:  c = 8'h4B;
                3'b001:  c = 8'h47;
                default: c = 8'h4F;
            endcase
            4: case (p[3:0])
                4'b1111: c = 8'h48;
                4'b1110: c = 8'h56;
                4'b1101: c = 8'h46;
                4'b1011: c = 8'h4C;
                4'b1001: c = 8'h50;
                4'b1000: c = 8'h4A;
                4'b0111: c = 8'h42;
                4'b0110: c = 8'h58;
                4'b0101: c = 8'h43;
                4'b0100: c = 8'h59;
                4'b0011: c = 8'h5A;
                4'b0010: c = 8'h51;
                default: c = QMARK;
            endcase
            5: case (p[4:0])
                5'b10000: c = 8'h31;
                5'b11000: c = 8'h32;
                5'b11100: c = 8'h33;
                5'b11110: c = 8'h34;
                5'b11111: c = 8'h35;
                5'b01111: c = 8'h36;
                5'b00111: c = 8'h37;
                5'b00011: c = 8'h38;
                5'b00001: c = 8'h39;
                5'b00000: c = 8'h30;
                default:  c = QMARK;
            endcase
            default: c = QMARK;
        endcase
        if (e) c = QMARK;
        return c;
    endfunction

    // FSM state, space flag and registered capture clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            space_pending <= 1'b0;
            cap_clr       <= 1'b0;
        end else begin
            state         <= state_nxt;
            space_pending <= sp_nxt;
            cap_clr       <= (state_nxt != IDLE);
        end
    end

    // Snapshot of the completed character, decoded during EMIT
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_len <= '0;
            lat_pat <= '0;
            lat_err <= 1'b0;
        end else if (latch_en) begin
            lat_len <= len;
            lat_pat <= dits_dahs;
            lat_err <= error;
        end
    end

    // Next-state logic and FIFO push request
    always_comb begin
        state_nxt = state;
        sp_nxt    = space_pending;
        latch_en  = 1'b0;
        push      = 1'b0;
        push_data = QMARK;
        unique case (state)
            IDLE: begin
                if (char_end && len != '0) begin
                    latch_en  = 1'b1;
                    state_nxt = EMIT;
                end else if (word_end && len == '0 && space_pending) begin
                    state_nxt = SPACE;
                end else if (len != '0 && !char_end) begin
                    sp_nxt = 1'b0;
                end
            end
            EMIT: begin
                push      = 1'b1;
                push_data = decode(lat_len, lat_pat, lat_err);
                sp_nxt    = 1'b1;
                state_nxt = IDLE;
            end
            SPACE: begin
                push      = 1'b1;
                push_data = SPC;
                sp_nxt    = 1'b0;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign do_pop   = out_valid && out_ready;
    assign do_write = push && (count != FULL);

    // Circular text buffer; a push into a full buffer is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && count == FULL) overflow <= 1'b1;
            case ({do_write, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    assign out_data   = mem[rd_ptr];
    assign out_valid  = (count != '0);
    assign fifo_count = count;

endmodule
